// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, mouse command
// bytes, input filter depth and request-to-send length.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FINISH
  } tx_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;

  localparam int PS2_FILTER_DEPTH = 4;
  localparam int PS2_REQ_CYCLES   = 64;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter: byte request and
// completion status.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output tx_data, tx_start,
    input  busy, done, ack_err, timeout
  );

  modport slave (
    input  tx_data, tx_start,
    output busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_sync_filter.sv
// One PS/2 pin: 2-FF synchronizer, glitch filter that changes level only after
// PS2_FILTER_DEPTH equal samples, and a registered falling-edge pulse.
module ps2_sync_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0]                  sync_reg;
  logic [PS2_FILTER_DEPTH-2:0] hist_reg;
  logic                        level_reg;
  logic                        fall_reg;
  logic                        all_high;
  logic                        all_low;

  // Current synchronized sample plus the previous DEPTH-1 samples.
  assign all_high = &{hist_reg, sync_reg[1]};
  assign all_low  = ~|{hist_reg, sync_reg[1]};

  // Idle PS/2 lines are high, so everything resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= '1;
      hist_reg  <= '1;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pin};
      hist_reg <= {hist_reg[PS2_FILTER_DEPTH-3:0], sync_reg[1]};
      fall_reg <= level_reg & all_low;
      if (all_high) begin
        level_reg <= 1'b1;
      end else if (all_low) begin
        level_reg <= 1'b0;
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, ten data
// edges clocked by the device, acknowledge check and a saturating abort timer.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 65_000_000,
  parameter int INHIBIT_US     = 100,
  parameter int TIMEOUT_CYCLES = 975_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  ps2_host_tx_if.slave cmd
);

  localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int CNT_MAX = (INHIBIT_CYCLES > PS2_REQ_CYCLES) ? INHIBIT_CYCLES : PS2_REQ_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(PS2_REQ_CYCLES - 1);
  localparam logic [19:0]      TMO_LAST     = 20'(TIMEOUT_CYCLES - 1);

  // Index 0 = clock pin, index 1 = data pin.
  logic [1:0] pin_raw;
  logic [1:0] pin_level;
  logic [1:0] pin_fall;

  assign pin_raw = {ps2_data_in, ps2_clk_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pin
      ps2_sync_filter u_filter (
        .clk   (clk),
        .rst   (rst),
        .pin   (pin_raw[gi]),
        .level (pin_level[gi]),
        .fall  (pin_fall[gi])
      );
    end
  endgenerate

  logic clk_level, clk_fall, data_level;
  logic unused_data_fall;

  assign clk_level  = pin_level[0];
  assign clk_fall   = pin_fall[0];
  assign data_level = pin_level[1];
  // Only the level of the data pin matters to the host.
  assign unused_data_fall = pin_fall[1];

  tx_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       edge_cnt_reg, edge_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             data_drive_reg, data_drive_next;
  logic [19:0]      tmo_cnt_reg, tmo_cnt_next;
  logic             ack_err_reg, ack_err_next;
  logic             timeout_reg, timeout_next;
  logic             tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      edge_cnt_reg   <= '0;
      shift_reg      <= '0;
      data_drive_reg <= 1'b0;
      tmo_cnt_reg    <= '0;
      ack_err_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      edge_cnt_reg   <= edge_cnt_next;
      shift_reg      <= shift_next;
      data_drive_reg <= data_drive_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      ack_err_reg    <= ack_err_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign tmo_hit = (tmo_cnt_reg >= TMO_LAST);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    edge_cnt_next   = edge_cnt_reg;
    shift_next      = shift_reg;
    data_drive_next = data_drive_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    ack_err_next    = ack_err_reg;
    timeout_next    = timeout_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (cmd.tx_start) begin
          state_next   = ST_INHIBIT;
          cnt_next     = '0;
          shift_next   = cmd.tx_data;
          ack_err_next = 1'b0;
          timeout_next = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (cnt_reg == INHIBIT_LAST) begin
          state_next = ST_REQ;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (cnt_reg == REQ_LAST) begin
          // Keep the start bit low until the device's first falling edge.
          state_next      = ST_SEND;
          edge_cnt_next   = '0;
          data_drive_next = 1'b1;
          tmo_cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
        if (tmo_hit) begin
          state_next   = ST_FINISH;
          timeout_next = 1'b1;
        end else begin
          if (tmo_cnt_reg != '1) begin
            tmo_cnt_next = tmo_cnt_reg + 20'd1;
          end
          if (state_reg == ST_SEND) begin
            // edge_cnt_reg holds the number of edges already seen.
            if (clk_fall) begin
              edge_cnt_next = edge_cnt_reg + 4'd1;
              if (edge_cnt_reg < 4'd8) begin
                data_drive_next = ~shift_reg[edge_cnt_reg[2:0]];
              end else if (edge_cnt_reg == 4'd8) begin
                data_drive_next = ~odd_parity(shift_reg);
              end else begin
                data_drive_next = 1'b0;
                state_next      = ST_ACK;
              end
            end
          end else if (state_reg == ST_ACK) begin
            if (clk_fall) begin
              ack_err_next = data_level;
              state_next   = ST_WAIT_IDLE;
            end
          end else if (clk_level && data_level) begin
            state_next = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pin drives decode straight from the state register so reset frees the bus at once.
  assign ps2_clk_oe  = (state_reg == ST_INHIBIT) || (state_reg == ST_REQ);
  assign ps2_data_oe = (state_reg == ST_REQ) || ((state_reg == ST_SEND) && data_drive_reg);

  assign cmd.busy    = (state_reg != ST_IDLE);
  assign cmd.done    = (state_reg == ST_FINISH);
  assign cmd.ack_err = ack_err_reg;
  assign cmd.timeout = timeout_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx with a bus-functional PS/2
// device on open-drain lines; timings scaled down for short runs.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_HZ    = 1_000_000;
  localparam int INH_US    = 100;
  localparam int TMO       = 3000;
  localparam int HALF      = 15;
  localparam int LIMIT     = 20000;
  localparam int EXP_INH   = CLK_HZ / 1_000_000 * INH_US;
  localparam int EXP_REQ   = 64;

  typedef struct {
    logic [7:0] data;
    logic       ack_err;
    logic       timeout;
    logic       check_rx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_pin, ps2_data_pin;
  logic dev_clk_low, dev_data_low;
  int   dev_falls;
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;
  logic prev_done = 1'b0;

  exp_t       exp_q[$];
  logic [9:0] rx_q[$];
  exp_t       mon_e;
  logic [9:0] mon_r;

  ps2_host_tx_if cmd ();

  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .INHIBIT_US     (INH_US),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_pin),
    .ps2_data_in (ps2_data_pin),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .cmd         (cmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device side: wait for request-to-send, clock out nclk bits, then ack.
  task automatic device_frame(input logic ack_bit, input int nclk, input bit push);
    int n;
    logic [9:0] bits;
    bits = '0;
    dev_falls = 0;
    n = 0;
    while (ps2_clk_pin && n < LIMIT) begin tick(1); n++; end
    n = 0;
    while (!(ps2_clk_pin && !ps2_data_pin) && n < LIMIT) begin tick(1); n++; end
    check("rts_seen", {30'd0, ps2_clk_pin, ps2_data_pin}, 32'd2);
    tick(HALF);
    for (int k = 0; k < nclk; k++) begin
      dev_clk_low = 1'b1;
      dev_falls++;
      tick(HALF);
      dev_clk_low = 1'b0;
      bits[k] = ps2_data_pin;
      tick(HALF);
    end
    if (push) rx_q.push_back(bits);
    if (nclk == 10) begin
      dev_data_low = ~ack_bit;
      tick(3);
      dev_clk_low = 1'b1;
      dev_falls++;
      tick(HALF);
      dev_clk_low = 1'b0;
      tick(3);
      dev_data_low = 1'b0;
      tick(HALF);
    end
  endtask

  // Issue a request and measure the inhibit / request-to-send phases.
  task automatic send_cmd(input logic [7:0] d);
    int n;
    tick(1);
    cmd.tx_data  = d;
    cmd.tx_start = 1'b1;
    tick(1);
    cmd.tx_start = 1'b0;
    cmd.tx_data  = 8'($urandom);
    @(negedge clk);
    check("start_clk_oe", ps2_clk_oe, 1);
    check("start_busy", cmd.busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < LIMIT) begin n++; @(negedge clk); end
    check("inhibit_len", n, EXP_INH);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < LIMIT) begin n++; @(negedge clk); end
    check("req_len", n, EXP_REQ);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cmd.busy && n < LIMIT) begin @(negedge clk); n++; end
    check("frame_end_busy", cmd.busy, 0);
  endtask

  task automatic wait_falls(input int k);
    int n;
    n = 0;
    while (dev_falls < k && n < LIMIT) begin tick(1); n++; end
    check("device_edges", (dev_falls >= k), 1);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic ack, input bit poke);
    exp_q.push_back(exp_t'{data: d, ack_err: ack, timeout: 1'b0, check_rx: 1'b1});
    fork
      begin
        send_cmd(d);
        if (poke) begin
          wait_falls(3);
          tick(2);
          cmd.tx_data  = 8'h00;
          cmd.tx_start = 1'b1;
          tick(1);
          cmd.tx_start = 1'b0;
          @(negedge clk);
          check("ignored_start_busy", cmd.busy, 1);
          check("ignored_start_clk_oe", ps2_clk_oe, 0);
        end
      end
      device_frame(ack, 10, 1'b1);
    join
    wait_idle();
    tick(5);
    @(negedge clk);
    check("ack_err_hold", cmd.ack_err, ack);
    check("timeout_hold", cmd.timeout, 0);
    check("no_restart", ps2_clk_oe, 0);
  endtask

  // Scoreboard monitor: every done pulse is matched against the expectation queue.
  always @(negedge clk) begin
    if (cmd.done) begin
      check("done_single", prev_done, 0);
      check("done_clk_oe", ps2_clk_oe, 0);
      check("done_data_oe", ps2_data_oe, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        txn++;
        $display("txn %0d: data=%02h ack_err=%0b timeout=%0b", txn, mon_e.data, cmd.ack_err, cmd.timeout);
        check("ack_err", cmd.ack_err, mon_e.ack_err);
        check("timeout", cmd.timeout, mon_e.timeout);
        if (mon_e.check_rx) begin
          if (rx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_missing: actual=none required=%02h", mon_e.data);
          end else begin
            mon_r = rx_q.pop_front();
            check("rx_data", mon_r[7:0], mon_e.data);
            check("rx_parity", mon_r[8], ($countones(mon_e.data) % 2 == 0) ? 1 : 0);
            check("rx_stop", mon_r[9], 1);
          end
        end
      end
    end
    prev_done <= cmd.done;
  end

  initial begin
    logic [7:0] rd;
    logic       ra;
    int         n;
    rst          = 1'b1;
    cmd.tx_start = 1'b0;
    cmd.tx_data  = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    dev_falls    = 0;
    tick(5);
    @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", cmd.busy, 0);
    check("rst_done", cmd.done, 0);
    check("rst_ack_err", cmd.ack_err, 0);
    check("rst_timeout", cmd.timeout, 0);
    tick(1);
    rst = 1'b0;
    tick(10);

    run_frame(PS2_CMD_ENABLE, 1'b0, 1'b0);
    run_frame(PS2_CMD_RESET, 1'b1, 1'b0);

    // Reset in the middle of SEND, right after edge 5 drives a 0 bit.
    fork
      begin
        send_cmd(8'h0F);
        wait_falls(5);
        tick(10);
        @(negedge clk);
        check("edge5_data_oe", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_clk_oe", ps2_clk_oe, 0);
        check("async_rst_data_oe", ps2_data_oe, 0);
        check("async_rst_busy", cmd.busy, 0);
      end
      device_frame(1'b0, 5, 1'b0);
    join
    tick(3);
    rst = 1'b0;
    tick(20);
    run_frame(PS2_CMD_ENABLE, 1'b0, 1'b0);

    // A request while busy must not disturb the frame in flight.
    run_frame(PS2_CMD_ENABLE, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      run_frame(rd, ra, 1'b0);
    end
    run_frame(PS2_CMD_SET_RATE, 1'b0, 1'b0);

    // Silent device: abort after TMO cycles of released clock.
    exp_q.push_back(exp_t'{data: 8'hA5, ack_err: 1'b0, timeout: 1'b1, check_rx: 1'b0});
    send_cmd(8'hA5);
    n = 0;
    while (!cmd.done && n < TMO + 500) begin @(negedge clk); n++; end
    check("timeout_latency", n, TMO);
    wait_idle();
    tick(5);
    @(negedge clk);
    check("timeout_flag_hold", cmd.timeout, 1);
    check("timeout_lines_clk", ps2_clk_oe, 0);
    check("timeout_lines_data", ps2_data_oe, 0);

    tick(5);
    check("exp_queue_empty", exp_q.size(), 0);
    check("rx_queue_empty", rx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
